// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module      : spi_ctrl_pkg
// Description : Shared definitions for the spi_ctrl sequencer/arbiter:
//               FSM state encoding, control/status bit positions, the fill
//               byte sent on reads and the control register reset value.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
package spi_ctrl_pkg;

  // Sequencer states. WAIT covers an engine that may still be mid-byte after
  // a reset, since the engine itself is not reset.
  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_t;

  // Control register bit positions
  localparam int CB_SDCS = 0;
  localparam int CB_FLCS = 1;
  localparam int CB_MODE = 2;

  // Status register bit positions
  localparam int SB_BUSY = 0;
  localparam int SB_PEND = 1;
  localparam int SB_OVR  = 2;

  localparam logic [7:0] FILL_BYTE = 8'hFF;
  localparam logic [7:0] CTRL_RST  = 8'h03;

  function automatic logic [7:0] pack_status(input logic busy,
                                             input logic pend,
                                             input logic ovr);
    logic [7:0] s;
    s          = '0;
    s[SB_BUSY] = busy;
    s[SB_PEND] = pend;
    s[SB_OVR]  = ovr;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_arb.sv
`default_nettype none
//==============================================================================
// Module      : spi_arb
// Description : Two-requester last-served arbiter (CPU vs DMA). With a single
//               requester that requester wins; with both, the one not served
//               last wins, so neither waits more than one byte.
// Ports       : clk, rst_n          - clock, async active-low reset
//               cpu, dma            - request levels
//               grant_en            - a grant is being taken this cycle
//               grant_dma           - 1: DMA wins, 0: CPU wins
// Revision    : 1.0 - initial release
//==============================================================================
module spi_arb
  import spi_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic cpu,
  input  logic dma,
  input  logic grant_en,
  output logic grant_dma
);

  logic r_last_dma;

  assign grant_dma = dma & (~cpu | ~r_last_dma);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_dma <= 1'b0;
    end else if (grant_en) begin
      r_last_dma <= grant_dma;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : spi_ctrl
// Description : Sequencer and arbiter in front of the SPI byte-exchange
//               engine. Holds the CS/mode control register and a one-entry
//               CPU request latch, arbitrates the engine between CPU and DMA,
//               never lets a start through while a byte is in flight, and
//               returns each received byte to its requester.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               cpu_wr_data/cpu_rd_data       - CPU send strobes (data / 8'hFF)
//               cpu_wr_ctrl, cpu_din          - control write strobe, CPU data
//               cpu_dout, status              - CPU result byte, status byte
//               sd_cs_n, fl_cs_n              - chip selects
//               dma_req/dma_wr/dma_din        - DMA request, direction, data
//               dma_ack/dma_dout              - DMA byte done, received byte
//               eng_req/eng_din/eng_mode      - engine request, data, CPHA
//               eng_start/eng_dout            - engine start strobe, result
// Revision    : 1.0 - initial release
//==============================================================================
module spi_ctrl #(
  parameter int         BYTE_CLKS = 16,
  parameter logic [7:0] CTRL_RST  = spi_ctrl_pkg::CTRL_RST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_wr_data,
  input  logic       cpu_rd_data,
  input  logic       cpu_wr_ctrl,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic [7:0] status,
  output logic       sd_cs_n,
  output logic       fl_cs_n,
  input  logic       dma_req,
  input  logic       dma_wr,
  input  logic [7:0] dma_din,
  output logic       dma_ack,
  output logic [7:0] dma_dout,
  output logic       eng_req,
  output logic [7:0] eng_din,
  output logic       eng_mode,
  input  logic       eng_start,
  input  logic [7:0] eng_dout
);
  import spi_ctrl_pkg::*;

  localparam logic [4:0] c_WAIT_LOAD  = 5'(BYTE_CLKS + 1);
  localparam logic [4:0] c_SHIFT_LOAD = 5'(BYTE_CLKS - 1);

  spi_state_t r_state;
  spi_state_t w_state_nxt;
  logic [4:0] r_cnt;
  logic [4:0] w_cnt_nxt;

  logic [2:0] r_ctrl;
  logic       r_mode_act;
  logic       r_cpu_pend;
  logic       r_overrun;
  logic       r_own_dma;
  logic [7:0] r_cpu_byte;
  logic [7:0] r_cpu_dout;
  logic [7:0] r_dma_dout;

  logic       w_cpu_strobe;
  logic [7:0] w_cpu_load;
  logic       w_req;
  logic       w_start;
  logic       w_done;
  logic       w_grant_dma;
  logic       w_cpu_clr;
  logic       w_ack;

  assign w_cpu_strobe = cpu_wr_data | cpu_rd_data;
  assign w_cpu_load   = cpu_wr_data ? cpu_din : FILL_BYTE;
  assign w_req        = r_cpu_pend | dma_req;

  //--------------------------------------------------------------------------
  // Arbiter: grant taken only on an accepted engine start
  //--------------------------------------------------------------------------
  spi_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (r_cpu_pend),
    .dma       (dma_req),
    .grant_en  (w_start),
    .grant_dma (w_grant_dma)
  );

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT;
      r_cnt   <= c_WAIT_LOAD;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state and per-state strobes
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    eng_req     = 1'b0;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_WAIT: begin
        // IDLE is reached on the edge where the count hits zero
        if (r_cnt <= 5'd1) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end
      ST_IDLE: begin
        eng_req = w_req;
        if (eng_start && w_req) begin
          w_start     = 1'b1;
          w_cnt_nxt   = c_SHIFT_LOAD;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == 5'd0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = c_WAIT_LOAD;
      end
    endcase
  end

  assign w_cpu_clr = w_start & ~w_grant_dma;
  assign w_ack     = w_done & r_own_dma;

  //--------------------------------------------------------------------------
  // Control register and active mode. The mode is copied on every edge that
  // lands in IDLE, so it is settled before a start and frozen while shifting.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= CTRL_RST[2:0];
      r_mode_act <= 1'b0;
    end else begin
      if (cpu_wr_ctrl) begin
        r_ctrl <= cpu_din[2:0];
      end
      if (w_state_nxt == ST_IDLE) begin
        r_mode_act <= r_ctrl[CB_MODE];
      end
    end
  end

  //--------------------------------------------------------------------------
  // CPU request latch. A strobe is dropped only if the latch stays full this
  // cycle; a strobe on the CPU start cycle refills the emptying latch.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_pend <= 1'b0;
      r_cpu_byte <= FILL_BYTE;
      r_overrun  <= 1'b0;
    end else begin
      if (cpu_wr_ctrl) begin
        r_overrun <= 1'b0;
      end
      if (w_cpu_strobe && r_cpu_pend && !w_cpu_clr) begin
        r_overrun <= 1'b1;
      end else if (w_cpu_strobe) begin
        r_cpu_pend <= 1'b1;
        r_cpu_byte <= w_cpu_load;
      end else if (w_cpu_clr) begin
        r_cpu_pend <= 1'b0;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Ownership and result capture
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own_dma  <= 1'b0;
      r_cpu_dout <= FILL_BYTE;
      r_dma_dout <= FILL_BYTE;
    end else begin
      if (w_start) begin
        r_own_dma <= w_grant_dma;
      end
      if (w_done) begin
        if (r_own_dma) begin
          r_dma_dout <= eng_dout;
        end else begin
          r_cpu_dout <= eng_dout;
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // Outputs. The DMA byte is passed straight through during the ack cycle so
  // it is valid together with dma_ack, then held from the register.
  //--------------------------------------------------------------------------
  assign eng_din  = w_grant_dma ? (dma_wr ? dma_din : FILL_BYTE) : r_cpu_byte;
  assign eng_mode = r_mode_act;
  assign sd_cs_n  = r_ctrl[CB_SDCS];
  assign fl_cs_n  = r_ctrl[CB_FLCS];
  assign dma_ack  = w_ack;
  assign dma_dout = w_ack ? eng_dout : r_dma_dout;
  assign cpu_dout = r_cpu_dout;
  assign status   = pack_status((r_state != ST_IDLE) | r_cpu_pend,
                                r_cpu_pend, r_overrun);

endmodule
`default_nettype wire

// File: tb/tb_spi_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : tb_spi_ctrl
// Description : Self-checking bench for spi_ctrl with a behavioural SPI engine.
//               Stimulus pushes expected engine starts into a scoreboard; a
//               monitor pops them on each start and checks the returned bytes.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_spi_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_wr_data = 1'b0;
  logic       cpu_rd_data = 1'b0;
  logic       cpu_wr_ctrl = 1'b0;
  logic [7:0] cpu_din = 8'h00;
  logic [7:0] cpu_dout;
  logic [7:0] status;
  logic       sd_cs_n;
  logic       fl_cs_n;
  logic       dma_req = 1'b0;
  logic       dma_wr = 1'b0;
  logic [7:0] dma_din = 8'h00;
  logic       dma_ack;
  logic [7:0] dma_dout;
  logic       eng_req;
  logic [7:0] eng_din;
  logic       eng_mode;
  logic       eng_start;
  logic [7:0] eng_dout = 8'hFF;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_ctrl #(.BYTE_CLKS(16), .CTRL_RST(8'h03)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data),
    .cpu_wr_ctrl (cpu_wr_ctrl),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .status      (status),
    .sd_cs_n     (sd_cs_n),
    .fl_cs_n     (fl_cs_n),
    .dma_req     (dma_req),
    .dma_wr      (dma_wr),
    .dma_din     (dma_din),
    .dma_ack     (dma_ack),
    .dma_dout    (dma_dout),
    .eng_req     (eng_req),
    .eng_din     (eng_din),
    .eng_mode    (eng_mode),
    .eng_start   (eng_start),
    .eng_dout    (eng_dout)
  );

  // Engine model: starts whenever requested and idle, busy 16 clocks, shows
  // garbage while shifting and the received byte once it goes idle.
  int         eng_cnt = 0;
  logic [7:0] eng_rx_next = 8'hFF;
  logic [7:0] eng_rx_cur = 8'hFF;
  assign eng_start = eng_req && (eng_cnt == 0);

  always @(posedge clk) begin
    if (eng_start) begin
      eng_cnt    <= 16;
      eng_rx_cur <= eng_rx_next;
      eng_dout   <= ~eng_rx_next;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) eng_dout <= eng_rx_cur;
    end
  end

  // Scoreboard
  typedef struct { logic [7:0] din; bit is_dma; logic [7:0] rx; } start_t;
  typedef struct { int t; logic [7:0] rx; } chk_t;
  start_t q_start[$];
  chk_t   q_cpu[$];
  chk_t   q_dma[$];
  int     ack_times[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_start(input logic [7:0] din, input bit is_dma,
                           input logic [7:0] rx);
    start_t e;
    e.din = din; e.is_dma = is_dma; e.rx = rx;
    q_start.push_back(e);
  endtask

  // Monitor: samples 1ns after the falling edge, after stimulus has settled
  always begin
    start_t e;
    chk_t   c;
    @(negedge clk);
    #1;
    if (rst_n && eng_start) begin
      if (q_start.size() == 0) begin
        check("unexpected_start", {24'd0, eng_din}, 32'hFFFF_FFFF);
      end else begin
        e = q_start.pop_front();
        check("eng_din", {24'd0, eng_din}, {24'd0, e.din});
        eng_rx_next = e.rx;
        c.rx = e.rx;
        if (e.is_dma) begin c.t = cyc + 17; q_dma.push_back(c); end
        else          begin c.t = cyc + 18; q_cpu.push_back(c); end
      end
    end
    if (rst_n && dma_ack) begin
      ack_times.push_back(cyc);
      if (q_dma.size() == 0) begin
        check("unexpected_ack", {24'd0, dma_dout}, 32'hFFFF_FFFF);
      end else begin
        c = q_dma.pop_front();
        check("dma_ack_time", cyc, c.t);
        check("dma_dout", {24'd0, dma_dout}, {24'd0, c.rx});
      end
    end
    if (q_cpu.size() != 0 && q_cpu[0].t == cyc) begin
      c = q_cpu.pop_front();
      check("cpu_dout", {24'd0, cpu_dout}, {24'd0, c.rx});
    end
  end

  task automatic cpu_strobe(input bit rd, input logic [7:0] d);
    cpu_wr_data = ~rd;
    cpu_rd_data = rd;
    cpu_din     = d;
    @(negedge clk);
    cpu_wr_data = 1'b0;
    cpu_rd_data = 1'b0;
  endtask

  task automatic ctrl_write(input logic [7:0] d);
    cpu_wr_ctrl = 1'b1;
    cpu_din     = d;
    @(negedge clk);
    cpu_wr_ctrl = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q_start.size() != 0 || q_cpu.size() != 0 || q_dma.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    check(name, (n < 100), 1);
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dma_ack && n < 60);
    check(name, (n < 60), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- power-up reset values and WAIT length
    repeat (3) @(negedge clk);
    check("rst_status",   {24'd0, status},   32'h01);
    check("rst_cpu_dout", {24'd0, cpu_dout}, 32'hFF);
    check("rst_dma_dout", {24'd0, dma_dout}, 32'hFF);
    check("rst_sd_cs_n",  sd_cs_n,  1);
    check("rst_fl_cs_n",  fl_cs_n,  1);
    check("rst_eng_mode", eng_mode, 0);
    check("rst_dma_ack",  dma_ack,  0);
    check("rst_eng_req",  eng_req,  0);
    rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      check("wait_status", {24'd0, status}, (i < 17) ? 32'h01 : 32'h00);
    end

    // ---------------- CPU write A5, MISO high
    exp_start(8'hA5, 1'b0, 8'hFF);
    cpu_strobe(1'b0, 8'hA5);
    check("wr_status_pend", {24'd0, status}, 32'h03);
    drain("drain_wr_a5");
    check("wr_status_done", {24'd0, status}, 32'h00);

    // ---------------- CPU read: sends fill byte
    exp_start(8'hFF, 1'b0, 8'h5A);
    cpu_strobe(1'b1, 8'h12);
    drain("drain_rd");
    check("rd_status_done", {24'd0, status}, 32'h00);

    // ---------------- overrun: second queued strobe dropped
    exp_start(8'h11, 1'b0, 8'h21);
    exp_start(8'h33, 1'b0, 8'h43);
    cpu_strobe(1'b0, 8'h11);
    repeat (3) @(negedge clk);
    cpu_strobe(1'b0, 8'h33);
    @(negedge clk);
    cpu_strobe(1'b0, 8'h55);
    check("ovr_status", {24'd0, status}, 32'h07);
    ctrl_write(8'h03);
    check("ovr_cleared", {24'd0, status}, 32'h03);
    drain("drain_ovr");
    check("ovr_status_done", {24'd0, status}, 32'h00);

    // ---------------- DMA burst of three with a CPU byte mid-burst
    exp_start(8'h81, 1'b1, 8'h91);
    exp_start(8'hC1, 1'b0, 8'hD1);
    exp_start(8'h82, 1'b1, 8'h92);
    exp_start(8'h83, 1'b1, 8'h93);
    ack_times.delete();
    dma_din = 8'h81;
    dma_wr  = 1'b1;
    dma_req = 1'b1;
    fork
      begin
        for (int k = 1; k <= 3; k++) begin
          wait_ack("burst_ack_wait");
          dma_din = 8'h81 + 8'(k);
          if (k == 3) dma_req = 1'b0;
        end
      end
      begin
        repeat (6) @(negedge clk);
        cpu_strobe(1'b0, 8'hC1);
      end
    join
    drain("drain_burst");
    check("burst_ack_count", ack_times.size(), 3);
    if (ack_times.size() == 3) begin
      check("burst_gap_cpu", ack_times[1] - ack_times[0], 36);
      check("burst_gap_b2b", ack_times[2] - ack_times[1], 18);
    end

    // ---------------- control write mid-byte: CS now, mode at next IDLE
    exp_start(8'h5E, 1'b0, 8'h6E);
    cpu_strobe(1'b0, 8'h5E);
    repeat (4) @(negedge clk);
    ctrl_write(8'h04);
    check("cs_sd_next", sd_cs_n, 0);
    check("cs_fl_next", fl_cs_n, 0);
    begin
      int n;
      n = 0;
      while (status[0] && n < 40) begin
        check("mode_held", eng_mode, 0);
        @(negedge clk);
        n++;
      end
      check("mode_wait_bound", (n < 40), 1);
    end
    check("mode_at_idle", eng_mode, 1);
    drain("drain_ctrl");

    // ---------------- DMA read sends fill byte, result held after ack
    exp_start(8'hFF, 1'b1, 8'hC3);
    dma_din = 8'h77;
    dma_wr  = 1'b0;
    dma_req = 1'b1;
    wait_ack("rd_ack_wait");
    dma_req = 1'b0;
    repeat (3) @(negedge clk);
    check("dma_dout_held", {24'd0, dma_dout}, 32'hC3);
    check("cpu_dout_kept", {24'd0, cpu_dout}, 32'h6E);
    drain("drain_dma_rd");

    // ---------------- reset while the engine is shifting
    exp_start(8'h99, 1'b0, 8'hAA);
    cpu_strobe(1'b0, 8'h99);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    q_cpu.delete();
    dma_din = 8'h3D;
    dma_wr  = 1'b1;
    dma_req = 1'b1;
    @(negedge clk);
    check("mid_rst_status",   {24'd0, status},   32'h01);
    check("mid_rst_cpu_dout", {24'd0, cpu_dout}, 32'hFF);
    check("mid_rst_dma_dout", {24'd0, dma_dout}, 32'hFF);
    check("mid_rst_eng_req",  eng_req, 0);
    exp_start(8'h3D, 1'b1, 8'h4D);
    rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      check("mid_wait_req",    eng_req, (i < 17) ? 0 : 1);
      check("mid_wait_status", {24'd0, status}, (i < 17) ? 32'h01 : 32'h00);
    end
    wait_ack("mid_ack_wait");
    dma_req = 1'b0;
    drain("drain_mid_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_ctrl.md
# spi_ctrl

Sequencer and arbiter in front of the `spi` byte-exchange engine in the TS peripheral block. It owns the SD/flash chip-select and SPI-mode control register, holds one pending Z80 transfer, and shares the engine between the Z80 port interface and the DMA SPI channel. It gates every engine start so that no request is issued while a byte is in flight. It also returns received bytes to the correct requester.

## Interface
- `BYTE_CLKS`, default 16: engine clocks per byte, from start strobe to idle, excluding the start cycle.
- `CTRL_RST`, default 8'h03: reset value of the control register.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `cpu_wr_data`, in, 1: 1-clk strobe that sends `cpu_din`.
- `cpu_rd_data`, in, 1: 1-clk strobe that sends 8'hFF. `cpu_dout` shows the previous result.
- `cpu_wr_ctrl`, in, 1: 1-clk strobe that writes the control register from `cpu_din`.
- `cpu_din`, in, 8: Z80 data.
- `cpu_dout`, out, 8: last byte received for the CPU.
- `status`, out, 8: {5'b0, overrun, cpu_pend, busy}.
- `sd_cs_n`, out, 1: control bit 0.
- `fl_cs_n`, out, 1: control bit 1.
- `dma_req`, in, 1: level; DMA byte wanted.
- `dma_wr`, in, 1: 1 sends `dma_din`; 0 sends 8'hFF.
- `dma_din`, in, 8: DMA data. Sampled on the start cycle.
- `dma_ack`, out, 1: 1-clk pulse; byte done.
- `dma_dout`, out, 8: received byte. Valid from `dma_ack` and held until the next DMA `dma_ack`.
- `eng_req`, out, 1: request to the engine's CPU request input.
- `eng_din`, out, 8: byte to the engine.
- `eng_mode`, out, 1: engine mode (CPHA).
- `eng_start`, in, 1: engine start strobe.
- `eng_dout`, in, 8: engine result.

## Operation
- Control register bits: [0] `sd_cs_n`, [1] `fl_cs_n`, [2] mode, [7:3] ignored.
  - The CS bits drive the CS outputs the clock after the write, even mid-byte.
  - Mode goes into `mode_act`, which drives `eng_mode` and is updated only in IDLE.
  - A control write also clears `overrun`.
- CPU request latch, one entry: `cpu_pend` plus the data byte.
  - A data write or read strobe sets `cpu_pend` and loads `cpu_din` (write) or 8'hFF (read).
  - A strobe while `cpu_pend`=1 is dropped and sets `overrun`. The first byte is kept.
- FSM states are WAIT, IDLE, SHIFT and DONE. A 5-bit counter `cnt` is shared.
- WAIT: entered on reset with `cnt`=BYTE_CLKS+1. It decrements to 0 and then goes to IDLE. This covers a reset that lands mid-byte, because the engine has no reset.
- IDLE:
  - `eng_req`=1 combinationally when `cpu_pend` or `dma_req` is set.
  - The grant goes to the `spi_arb` winner. `eng_din` is the winner's byte.
  - On `eng_start`: record the owner, clear `cpu_pend` if the CPU owns the byte, load `cnt`=BYTE_CLKS-1, and go to SHIFT.
- SHIFT: decrement `cnt`. At 0, go to DONE. `eng_req`=0.
- DONE:
  - CPU owner: capture `eng_dout` into `cpu_dout`.
  - DMA owner: capture into `dma_dout` and pulse `dma_ack`.
  - Go to IDLE.
- Arbitration, in `spi_arb`:
  - With a single requester, that requester wins.
  - When both request, the `last_dma` flag decides: if set, the CPU wins; otherwise DMA wins.
  - `last_dma` is updated at each grant.
  - Neither requester can be starved for more than one byte.
- A CPU strobe in the same cycle as the IDLE grant does not join that grant. It is granted at the next IDLE.
- A strobe in the DONE cycle is accepted into the latch. A strobe in the cycle the latch clears (start cycle) is accepted, not overrun.
- busy = (state != IDLE) or `cpu_pend`.

## Timing
- Reset values:
  - `cpu_dout`=8'hFF, `dma_dout`=8'hFF.
  - `status`=8'h01 (busy, because the FSM is in WAIT).
  - `sd_cs_n`=1, `fl_cs_n`=1, `eng_mode`=0, `dma_ack`=0, `eng_req`=0.
  - `cpu_pend`=0, `overrun`=0, `last_dma`=0.
- After reset release: first IDLE at cycle 17.
- Byte period is BYTE_CLKS+2 = 18 clocks: start (IDLE) 1, SHIFT 16, DONE 1. Back-to-back starts are 18 clocks apart.
- `dma_ack` comes exactly 17 clocks after the start cycle.
- DMA must deassert `dma_req` in the `dma_ack` cycle if no further byte is wanted. `dma_req` still high in the following IDLE requests the next byte.
- `cpu_dout` updates at the DONE edge, i.e. 17 clocks after start.

## Structure
- Package `spi_ctrl_pkg` holds:
  - State encoding (WAIT/IDLE/SHIFT/DONE).
  - Control bit indices: CB_SDCS=0, CB_FLCS=1, CB_MODE=2.
  - Status bit indices.
  - FILL_BYTE=8'hFF and CTRL_RST.
- Sub-module `spi_arb`: 2-requester last-served arbiter with inputs cpu/dma, `grant_en`, `rst_n`, and output `grant_dma`.

## Test plan
- Reset mid-byte: pulse `rst_n` low while the engine is shifting → `eng_req` stays 0 for 17 clocks; `status`=8'h01 until IDLE, then 8'h00.
- CPU write 8'hA5 with MISO held 1 → `eng_din`=8'hA5 on start; `cpu_dout`=8'hFF 17 clocks later; `status`=8'h00 after DONE.
- Two CPU writes 2 clocks apart while busy → second dropped; `status`=8'h07; control write 8'h03 clears it to 8'h03.
- DMA `dma_req` held for 4 bytes while CPU writes once mid-burst → grant order DMA, CPU, DMA, DMA; `dma_ack` pulses 18 clocks apart, except one 36-clock gap around the CPU byte.
- Control write 8'h04 mid-byte → CS outputs update next clock; `eng_mode` changes only at the next IDLE.
- DMA read with `dma_wr`=0 → `eng_din`=8'hFF; `dma_dout`=received byte at `dma_ack`.
